stream_pack: RTL and testbench
==============================

Name: stream_pack

Overview:
- Width-converting stream stage between two stream FIFOs.
- Consumes narrow elements from an upstream stream's read side and packs RATIO consecutive elements into one wide word.
- Writes packed words into a downstream stream's write side.
- Handles end-of-stream by flushing a zero-padded partial word, then forwarding an eos marker. Used to widen pixel/coefficient streams before bus transfer.

Parameters:
- datawidth, 8: width of one input element.
- ratio, 4: input elements per output word; output width = datawidth*ratio.
- cntwidth, 2: lane counter width; must satisfy 2**cntwidth >= ratio.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_rdy  input  1  upstream stream holds an element (not empty).
- in_eos  input  1  head element is an eos marker; valid only when in_rdy=1.
- in_data  input  datawidth  head element payload; valid only when in_rdy=1.
- in_en  output  1  pops the upstream head element this cycle.
- out_rdy  input  1  downstream stream can accept a word (not full).
- out_en  output  1  pushes out_data/out_eos into the downstream stream this cycle.
- out_eos  output  1  the pushed word is an eos marker.
- out_data  output  datawidth*ratio  packed word.

Behaviour:
- Input element model:
  - An upstream element with eos=1 is a pure end marker. Its in_data is ignored and never packed.
  - Upstream is show-ahead: in_data/in_eos are valid whenever in_rdy=1. A pop occurs on a cycle with in_en=1.
- State machine states: FILL, EMIT, MARK. Registers: state, lane count cnt, packed buffer buf, flag pend.
- Reset: state=FILL, cnt=0, buf=0, pend=0. in_en and out_en are forced 0 in any cycle where reset=1.
- FILL:
  - in_en = in_rdy; out_en = 0.
  - Pop with eos=0: in_data is written to lane cnt, bits [cnt*datawidth +: datawidth]. Lane 0 is least significant. cnt increments.
  - If cnt was ratio-1: cnt returns to 0 and next state is EMIT.
  - Pop with eos=1 and cnt>0: pend<=1, next state EMIT. Unfilled lanes stay 0.
  - Pop with eos=1 and cnt=0: next state MARK.
- EMIT:
  - in_en = 0; out_data = buf; out_eos = 0; out_en = out_rdy.
  - On push: buf<=0, cnt<=0. Next state is MARK if pend=1 (pend clears), else FILL.
- MARK:
  - in_en = 0; out_data = 0; out_eos = 1; out_en = out_rdy.
  - On push: next state FILL, ready for the next packet.
- in_en, out_en, out_data and out_eos are combinational from registered state and the rdy inputs. There is no combinational path from in_* to out_*.
- Latency: a full word is pushed no earlier than 1 cycle after its last element is popped.
- Throughput: at most ratio elements per ratio+1 cycles.
- Backpressure:
  - While out_rdy=0 in EMIT/MARK, the state holds, out_data is stable and in_en stays 0. No element is lost or duplicated.
  - While in_rdy=0 in FILL, buf and cnt hold.
- A packet of N data elements produces ceil(N/ratio) data words followed by exactly one eos word. An empty packet (N=0) produces only the eos word.
- Reset asserted mid-packet discards buf, cnt and pend. The first element popped after reset goes to lane 0.

Optional Feature:
- Macro: STREAM_PACK_COUNT_EN.
- Defined: adds output port out_count, width cntwidth+1, giving the number of valid lanes in the word currently presented.
  - ratio for a full word.
  - k (1..ratio-1) for a flushed partial word.
  - 0 for an eos word.
  - 0 in FILL and during reset.
  - Requires an extra register holding the lane count of the word being emitted.
- Undefined: port and register absent; behaviour otherwise identical.

Test Plan:
- Defaults; push 0x01..0x08 then eos, out_rdy=1 -> pushes 0x04030201, 0x08070605, then eos word (out_eos=1, out_data=0); out_count 4, 4, 0 if enabled.
- Push 0x11..0x16 then eos -> 0x14131211, 0x00001615 (out_count=2), then eos word.
- Eos only -> exactly one eos word; no data word emitted.
- 4 elements queued, out_rdy=0 for 10 cycles -> state EMIT held, in_en=0, out_data=0x04030201 stable; on out_rdy=1, one push only.
- in_rdy toggled 1,0,0,1,0,1,1 with data 0xA0..0xA3 -> single word 0xA3A2A1A0; no duplicate or dropped elements.
- reset for 1 cycle after 2 pops (0xAA, 0xBB), then 0x01..0x04 -> single word 0x04030201; no 0xAA/0xBB residue.

Source files
------------

// File: rtl/stream_pack.sv
// stream_pack: packs `ratio` consecutive narrow stream elements into one wide word.
//
// Reads elements from a show-ahead upstream FIFO (in_rdy/in_eos/in_data, popped by
// in_en) and pushes packed words to a downstream FIFO (out_en/out_eos/out_data, gated
// by out_rdy). Lane 0 is the least significant slice of out_data. An eos element is a
// pure marker: any partially filled word is flushed zero-padded, then one eos word
// (out_eos=1, out_data=0) is forwarded.
//
// Ports:
//   clk       clock, rising edge
//   reset     synchronous, active-high
//   in_rdy    upstream holds an element
//   in_eos    head element is an eos marker
//   in_data   head element payload
//   in_en     pop upstream head this cycle
//   out_rdy   downstream can accept a word
//   out_en    push out_data/out_eos this cycle
//   out_eos   pushed word is an eos marker
//   out_data  packed word
//   out_count (only with STREAM_PACK_COUNT_EN) valid lanes in the presented word
//
// Optional build macro: STREAM_PACK_COUNT_EN adds out_count and its holding register.
//
// state | meaning
// FILL  | popping elements into lanes of buf_q
// EMIT  | presenting buf_q as a data word until downstream accepts it
// MARK  | presenting the eos word until downstream accepts it

module stream_pack #(
    parameter int datawidth = 8,
    parameter int ratio     = 4,
    parameter int cntwidth  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_rdy,
    input  logic                          in_eos,
    input  logic [datawidth-1:0]          in_data,
    output logic                          in_en,
    input  logic                          out_rdy,
    output logic                          out_en,
    output logic                          out_eos,
    output logic [datawidth*ratio-1:0]    out_data
`ifdef STREAM_PACK_COUNT_EN
    ,
    output logic [cntwidth:0]             out_count
`endif
);

    localparam logic [cntwidth-1:0] LAST_LANE = cntwidth'(ratio - 1);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        EMIT = 2'd1,
        MARK = 2'd2
    } state_t;

    state_t                       state_q;
    logic [cntwidth-1:0]          cnt_q;
    logic [datawidth*ratio-1:0]   buf_q;
    logic                         pend_q;
`ifdef STREAM_PACK_COUNT_EN
    logic [cntwidth:0]            count_q;
`endif

    // Handshakes depend only on registered state and the rdy inputs, so there is no
    // combinational path from in_* to out_*.
    always_comb begin
        in_en    = 1'b0;
        out_en   = 1'b0;
        out_eos  = 1'b0;
        out_data = '0;
        case (state_q)
            FILL: begin
                in_en = in_rdy & ~reset;
            end
            EMIT: begin
                out_en   = out_rdy & ~reset;
                out_data = buf_q;
            end
            MARK: begin
                out_en  = out_rdy & ~reset;
                out_eos = 1'b1;
            end
            default: begin
                in_en = 1'b0;
            end
        endcase
    end

`ifdef STREAM_PACK_COUNT_EN
    assign out_count = (state_q == EMIT && !reset) ? count_q : '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
            cnt_q   <= '0;
            buf_q   <= '0;
            pend_q  <= 1'b0;
`ifdef STREAM_PACK_COUNT_EN
            count_q <= '0;
`endif
        end else begin
            case (state_q)
                FILL: begin
                    if (in_en) begin
                        if (!in_eos) begin
                            for (int i = 0; i < ratio; i++) begin
                                if (cnt_q == cntwidth'(i)) begin
                                    buf_q[i*datawidth +: datawidth] <= in_data;
                                end
                            end
                            if (cnt_q == LAST_LANE) begin
                                cnt_q   <= '0;
                                state_q <= EMIT;
`ifdef STREAM_PACK_COUNT_EN
                                count_q <= (cntwidth+1)'(ratio);
`endif
                            end else begin
                                cnt_q <= cnt_q + cntwidth'(1);
                            end
                        end else if (cnt_q != '0) begin
                            // Flush the partial word first; pend_q routes EMIT to MARK.
                            pend_q  <= 1'b1;
                            state_q <= EMIT;
`ifdef STREAM_PACK_COUNT_EN
                            count_q <= {1'b0, cnt_q};
`endif
                        end else begin
                            state_q <= MARK;
                        end
                    end
                end
                EMIT: begin
                    if (out_en) begin
                        buf_q  <= '0;
                        cnt_q  <= '0;
`ifdef STREAM_PACK_COUNT_EN
                        count_q <= '0;
`endif
                        if (pend_q) begin
                            pend_q  <= 1'b0;
                            state_q <= MARK;
                        end else begin
                            state_q <= FILL;
                        end
                    end
                end
                MARK: begin
                    if (out_en) begin
                        state_q <= FILL;
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_pack.sv
// Self-checking bench for stream_pack (datawidth=8, ratio=4, cntwidth=2).
// Word records are {eos, lane count, data}; the count field is only checked when
// STREAM_PACK_COUNT_EN is defined.

module tb_stream_pack;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_rdy = 1'b0;
    logic        in_eos = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_en;
    logic        out_rdy = 1'b0;
    logic        out_en;
    logic        out_eos;
    logic [31:0] out_data;
`ifdef STREAM_PACK_COUNT_EN
    logic [2:0]  out_count;
`endif

    stream_pack #(.datawidth(8), .ratio(4), .cntwidth(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_rdy   (in_rdy),
        .in_eos   (in_eos),
        .in_data  (in_data),
        .in_en    (in_en),
        .out_rdy  (out_rdy),
        .out_en   (out_en),
        .out_eos  (out_eos),
        .out_data (out_data)
`ifdef STREAM_PACK_COUNT_EN
        ,
        .out_count(out_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        eos;
        logic [2:0]  cnt;
        logic [31:0] data;
    } word_t;

    typedef struct {
        int               n;
        logic [9:0][7:0]  el;
        int               nw;
        logic [3:0][35:0] ex;
    } vec_t;

    int checks = 0;
    int failures = 0;

    logic [8:0] src_q[$];   // {eos, data}, head = element presented upstream
    word_t      got_q[$];
    word_t      exp_q[$];

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_word(input string name, input word_t act, input word_t exp);
        chk({name, ".eos"}, {35'd0, act.eos}, {35'd0, exp.eos});
        chk({name, ".data"}, {4'd0, act.data}, {4'd0, exp.data});
`ifdef STREAM_PACK_COUNT_EN
        chk({name, ".count"}, {33'd0, act.cnt}, {33'd0, exp.cnt});
`endif
    endtask

    // One cycle: drive at the falling edge, sample 1 time unit later, account for
    // the handshakes that the following rising edge will commit.
    task automatic step(input int in_pct, input int out_pct, input bit rst);
        word_t w;
        @(negedge clk);
        reset  = rst;
        in_rdy = (src_q.size() > 0) && ($urandom_range(0, 99) < in_pct);
        if (in_rdy) begin
            in_eos  = src_q[0][8];
            in_data = src_q[0][7:0];
        end else begin
            in_eos  = $urandom_range(0, 1);
            in_data = 8'($urandom);
        end
        out_rdy = ($urandom_range(0, 99) < out_pct);
        #1;
        if (in_en && !in_rdy) chk("pop_without_rdy", {35'd0, in_en}, 36'd0);
        if (out_en && !out_rdy) chk("push_without_rdy", {35'd0, out_en}, 36'd0);
        if (in_en && in_rdy) void'(src_q.pop_front());
        if (out_en) begin
            w.eos  = out_eos;
            w.data = out_data;
`ifdef STREAM_PACK_COUNT_EN
            w.cnt  = out_count;
`else
            w.cnt  = 3'd0;
`endif
            got_q.push_back(w);
        end
    endtask

    task automatic run_until(input string name, input int n, input int in_pct,
                             input int out_pct, input int budget);
        int cyc = 0;
        while (got_q.size() < n && cyc < budget) begin
            step(in_pct, out_pct, 1'b0);
            cyc++;
        end
        if (got_q.size() < n) chk({name, ".timeout_words"}, 36'(got_q.size()), 36'(n));
    endtask

    // Reference: chunk the packet into groups of four, zero-pad the tail, then eos.
    task automatic model_packet(input logic [7:0] d[$]);
        int n = d.size();
        for (int w = 0; w * 4 < n; w++) begin
            word_t x;
            int c = 0;
            x = '0;
            for (int j = 0; j < 4; j++) begin
                if (w * 4 + j < n) begin
                    x.data = x.data | (32'(d[w*4+j]) << (8 * j));
                    c++;
                end
            end
            x.cnt = 3'(c);
            exp_q.push_back(x);
        end
        exp_q.push_back('{eos: 1'b1, cnt: 3'd0, data: 32'd0});
    endtask

    vec_t vec[5];
    logic [7:0] pkt[$];
    int np;
    int tog[7] = '{1, 0, 0, 1, 0, 1, 1};

    initial begin
        vec[0] = '{8, {16'h0, 64'h0807060504030201}, 3,
                   {36'h0, {1'b1, 3'd0, 32'h0}, {1'b0, 3'd4, 32'h08070605}, {1'b0, 3'd4, 32'h04030201}}};
        vec[1] = '{6, {32'h0, 48'h161514131211}, 3,
                   {36'h0, {1'b1, 3'd0, 32'h0}, {1'b0, 3'd2, 32'h00001615}, {1'b0, 3'd4, 32'h14131211}}};
        vec[2] = '{0, 80'h0, 1,
                   {36'h0, 36'h0, 36'h0, {1'b1, 3'd0, 32'h0}}};
        vec[3] = '{1, {72'h0, 8'h5A}, 2,
                   {36'h0, 36'h0, {1'b1, 3'd0, 32'h0}, {1'b0, 3'd1, 32'h0000005A}}};
        vec[4] = '{4, {48'h0, 32'hEFBEADDE}, 2,
                   {36'h0, 36'h0, {1'b1, 3'd0, 32'h0}, {1'b0, 3'd4, 32'hEFBEADDE}}};

        // Reset state
        repeat (3) step(100, 100, 1'b1);
        step(100, 100, 1'b0);
        chk("rst.in_en", {35'd0, in_en}, 36'd0);
        chk("rst.out_en", {35'd0, out_en}, 36'd0);
        chk("rst.out_eos", {35'd0, out_eos}, 36'd0);
        chk("rst.out_data", {4'd0, out_data}, 36'd0);

        // Table-driven packets with no backpressure
        for (int v = 0; v < 5; v++) begin
            got_q.delete();
            for (int j = 0; j < vec[v].n; j++) src_q.push_back({1'b0, vec[v].el[j]});
            src_q.push_back({1'b1, 8'($urandom)});
            run_until($sformatf("vec%0d", v), vec[v].nw, 100, 100, 100);
            repeat (3) step(100, 100, 1'b0);
            chk($sformatf("vec%0d.nwords", v), 36'(got_q.size()), 36'(vec[v].nw));
            for (int k = 0; k < vec[v].nw && k < got_q.size(); k++)
                chk_word($sformatf("vec%0d.w%0d", v, k), got_q[k], word_t'(vec[v].ex[k]));
        end

        // Backpressure: full word held in EMIT for 10 cycles
        got_q.delete();
        for (int j = 1; j <= 4; j++) src_q.push_back({1'b0, 8'(j)});
        src_q.push_back({1'b1, 8'h00});
        repeat (4) step(100, 0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            step(100, 0, 1'b0);
            chk("bp.in_en", {35'd0, in_en}, 36'd0);
            chk("bp.out_data", {4'd0, out_data}, {4'd0, 32'h04030201});
`ifdef STREAM_PACK_COUNT_EN
            chk("bp.out_count", {33'd0, out_count}, 36'd4);
`endif
        end
        chk("bp.eos_not_popped", 36'(src_q.size()), 36'd1);
        step(100, 100, 1'b0);
        chk("bp.one_push", 36'(got_q.size()), 36'd1);
        run_until("bp", 2, 100, 100, 50);
        repeat (3) step(100, 100, 1'b0);
        chk("bp.nwords", 36'(got_q.size()), 36'd2);
        if (got_q.size() >= 2) begin
            chk_word("bp.w0", got_q[0], '{eos: 1'b0, cnt: 3'd4, data: 32'h04030201});
            chk_word("bp.w1", got_q[1], '{eos: 1'b1, cnt: 3'd0, data: 32'h0});
        end

        // Upstream gaps: in_rdy pattern 1,0,0,1,0,1,1
        got_q.delete();
        for (int j = 0; j < 4; j++) src_q.push_back({1'b0, 8'hA0 + 8'(j)});
        src_q.push_back({1'b1, 8'h00});
        for (int c = 0; c < 7; c++) step(tog[c] * 100, 100, 1'b0);
        chk("tog.remaining", 36'(src_q.size()), 36'd1);
        run_until("tog", 2, 100, 100, 50);
        repeat (3) step(100, 100, 1'b0);
        chk("tog.nwords", 36'(got_q.size()), 36'd2);
        if (got_q.size() >= 2) begin
            chk_word("tog.w0", got_q[0], '{eos: 1'b0, cnt: 3'd4, data: 32'hA3A2A1A0});
            chk_word("tog.w1", got_q[1], '{eos: 1'b1, cnt: 3'd0, data: 32'h0});
        end

        // Reset mid-packet discards partial lanes
        got_q.delete();
        src_q.push_back({1'b0, 8'hAA});
        src_q.push_back({1'b0, 8'hBB});
        repeat (2) step(100, 100, 1'b0);
        for (int j = 1; j <= 4; j++) src_q.push_back({1'b0, 8'(j)});
        src_q.push_back({1'b1, 8'h00});
        step(100, 100, 1'b1);
        chk("mrst.in_en", {35'd0, in_en}, 36'd0);
        chk("mrst.out_en", {35'd0, out_en}, 36'd0);
        run_until("mrst", 2, 100, 100, 50);
        repeat (3) step(100, 100, 1'b0);
        chk("mrst.nwords", 36'(got_q.size()), 36'd2);
        if (got_q.size() >= 2) begin
            chk_word("mrst.w0", got_q[0], '{eos: 1'b0, cnt: 3'd4, data: 32'h04030201});
            chk_word("mrst.w1", got_q[1], '{eos: 1'b1, cnt: 3'd0, data: 32'h0});
        end

        // Randomised packets with random stalls on both sides
        got_q.delete();
        exp_q.delete();
        for (int p = 0; p < 40; p++) begin
            pkt.delete();
            np = $urandom_range(0, 11);
            for (int j = 0; j < np; j++) pkt.push_back(8'($urandom));
            foreach (pkt[j]) src_q.push_back({1'b0, pkt[j]});
            src_q.push_back({1'b1, 8'($urandom)});
            model_packet(pkt);
        end
        run_until("rand", exp_q.size(), 70, 60, 20000);
        repeat (5) step(100, 100, 1'b0);
        chk("rand.nwords", 36'(got_q.size()), 36'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            chk_word($sformatf("rand.w%0d", k), got_q[k], exp_q[k]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
